// File: rtl/ucsbece154b_scoreboard_pkg.sv
// Shared types and constants for the dual-issue register scoreboard.
// Register indices are 5 bits wide and x0 is hardwired to zero.
package ucsbece154b_scoreboard_pkg;

  localparam int REGW        = 5;
  localparam int NREGS       = 32;
  localparam int SB_CNTW_DEF = 32;

  typedef logic [REGW-1:0] regidx_t;

  localparam regidx_t X0 = regidx_t'(0);

  // One-hot mask for register r; x0 never produces a bit.
  function automatic logic [NREGS-1:0] reg_mask(input regidx_t r, input logic en);
    logic [NREGS-1:0] v;
    v = '0;
    if (en && (r != X0)) v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ucsbece154b_scoreboard_if.sv
// Decode, writeback and status signals between the issue stage and the scoreboard.
// Issue outputs are combinational; there is no backpressure, a slot issues in the cycle issueN_o is high.
interface ucsbece154b_scoreboard_if #(
  parameter int CNTW = ucsbece154b_scoreboard_pkg::SB_CNTW_DEF
);
  import ucsbece154b_scoreboard_pkg::*;

  logic            flush_i;
  logic            iv1_i, iv2_i;
  regidx_t         rs1_1_i, rs2_1_i, rd_1_i;
  regidx_t         rs1_2_i, rs2_2_i, rd_2_i;
  logic            uses_rs1_1_i, uses_rs2_1_i, we_1_i;
  logic            uses_rs1_2_i, uses_rs2_2_i, we_2_i;
  logic            wb_we1_i, wb_we2_i;
  regidx_t         wb_a1_i, wb_a2_i;
  logic            issue1_o, issue2_o;
  logic [NREGS-1:0] busy_o;
  logic            err_o;
  logic [CNTW-1:0] stall_cnt_o;
  logic [CNTW-1:0] dual_cnt_o;

  modport slave (
    input  flush_i, iv1_i, iv2_i,
    input  rs1_1_i, rs2_1_i, rd_1_i, rs1_2_i, rs2_2_i, rd_2_i,
    input  uses_rs1_1_i, uses_rs2_1_i, we_1_i,
    input  uses_rs1_2_i, uses_rs2_2_i, we_2_i,
    input  wb_we1_i, wb_we2_i, wb_a1_i, wb_a2_i,
    output issue1_o, issue2_o, busy_o, err_o, stall_cnt_o, dual_cnt_o
  );

  modport master (
    output flush_i, iv1_i, iv2_i,
    output rs1_1_i, rs2_1_i, rd_1_i, rs1_2_i, rs2_2_i, rd_2_i,
    output uses_rs1_1_i, uses_rs2_1_i, we_1_i,
    output uses_rs1_2_i, uses_rs2_2_i, we_2_i,
    output wb_we1_i, wb_we2_i, wb_a1_i, wb_a2_i,
    input  issue1_o, issue2_o, busy_o, err_o, stall_cnt_o, dual_cnt_o
  );

endinterface

// File: rtl/ucsbece154b_sb_hazard.sv
// Per-slot hazard check against the registered busy vector.
// RAW on any used source, or WAW on the destination, blocks the slot.
module ucsbece154b_sb_hazard
  import ucsbece154b_scoreboard_pkg::*;
(
  input  logic             i_iv,
  input  regidx_t          i_rs1,
  input  regidx_t          i_rs2,
  input  regidx_t          i_rd,
  input  logic             i_uses_rs1,
  input  logic             i_uses_rs2,
  input  logic             i_we,
  input  logic [NREGS-1:0] i_busy,
  output logic             o_ok
);

  logic w_rs1_haz;
  logic w_rs2_haz;
  logic w_rd_haz;

  assign w_rs1_haz = i_uses_rs1 && (i_rs1 != X0) && i_busy[i_rs1];
  assign w_rs2_haz = i_uses_rs2 && (i_rs2 != X0) && i_busy[i_rs2];
  assign w_rd_haz  = i_we       && (i_rd  != X0) && i_busy[i_rd];

  assign o_ok = i_iv && !w_rs1_haz && !w_rs2_haz && !w_rd_haz;

endmodule

// File: rtl/ucsbece154b_scoreboard.sv
// Dual-issue register scoreboard: tracks in-flight writes, gates in-order issue
// of two decode slots, and releases registers on register-file writeback.
module ucsbece154b_scoreboard
  import ucsbece154b_scoreboard_pkg::*;
#(
  parameter int CNTW = SB_CNTW_DEF
) (
  input logic                    clk,
  input logic                    reset_n,
  ucsbece154b_scoreboard_if.slave sb
);

  logic [NREGS-1:0] r_busy;
  logic             r_err;
  logic [CNTW-1:0]  r_stall_cnt;
  logic [CNTW-1:0]  r_dual_cnt;

  logic             w_ok1, w_ok2;
  logic             w_intra_blk;
  logic             w_issue1, w_issue2;
  logic [NREGS-1:0] w_set, w_clr;
  logic             w_err_hit;

  ucsbece154b_sb_hazard u_haz1 (
    .i_iv       (sb.iv1_i),
    .i_rs1      (sb.rs1_1_i),
    .i_rs2      (sb.rs2_1_i),
    .i_rd       (sb.rd_1_i),
    .i_uses_rs1 (sb.uses_rs1_1_i),
    .i_uses_rs2 (sb.uses_rs2_1_i),
    .i_we       (sb.we_1_i),
    .i_busy     (r_busy),
    .o_ok       (w_ok1)
  );

  ucsbece154b_sb_hazard u_haz2 (
    .i_iv       (sb.iv2_i),
    .i_rs1      (sb.rs1_2_i),
    .i_rs2      (sb.rs2_2_i),
    .i_rd       (sb.rd_2_i),
    .i_uses_rs1 (sb.uses_rs1_2_i),
    .i_uses_rs2 (sb.uses_rs2_2_i),
    .i_we       (sb.we_2_i),
    .i_busy     (r_busy),
    .o_ok       (w_ok2)
  );

  // Slot 2 may not read or overwrite the register slot 1 is producing this cycle.
  assign w_intra_blk = sb.we_1_i && (sb.rd_1_i != X0) &&
                       ((sb.uses_rs1_2_i && (sb.rs1_2_i == sb.rd_1_i)) ||
                        (sb.uses_rs2_2_i && (sb.rs2_2_i == sb.rd_1_i)) ||
                        (sb.we_2_i       && (sb.rd_2_i  == sb.rd_1_i)));

  assign w_issue1 = w_ok1 && !sb.flush_i;
  assign w_issue2 = w_ok2 && w_issue1 && !w_intra_blk;

  assign w_set = reg_mask(sb.rd_1_i, w_issue1 && sb.we_1_i) |
                 reg_mask(sb.rd_2_i, w_issue2 && sb.we_2_i);
  assign w_clr = reg_mask(sb.wb_a1_i, sb.wb_we1_i) |
                 reg_mask(sb.wb_a2_i, sb.wb_we2_i);

  // A writeback to an idle register is an error unless a new producer claims it in the same cycle.
  assign w_err_hit = |(w_clr & ~r_busy & ~w_set);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy      <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_dual_cnt  <= '0;
    end else begin
      if (sb.flush_i) begin
        r_busy <= '0;
      end else begin
        r_busy <= (r_busy & ~w_clr) | w_set;
        if (w_err_hit) r_err <= 1'b1;
      end
      if (sb.iv1_i && !w_issue1) r_stall_cnt <= r_stall_cnt + CNTW'(1);
      if (w_issue1 && w_issue2)  r_dual_cnt  <= r_dual_cnt + CNTW'(1);
    end
  end

  assign sb.issue1_o    = w_issue1;
  assign sb.issue2_o    = w_issue2;
  assign sb.busy_o      = r_busy;
  assign sb.err_o       = r_err;
  assign sb.stall_cnt_o = r_stall_cnt;
  assign sb.dual_cnt_o  = r_dual_cnt;

endmodule

// File: doc/ucsbece154b_scoreboard.md
# ucsbece154b_scoreboard

Dual-issue register scoreboard for the superscalar core's 32×32 register file (two read pairs, two write ports, x0 hardwired). Tracks which architectural registers have a write in flight, decides each cycle whether decode slot 1 and slot 2 may issue without RAW/WAW hazards, and releases registers as the two write ports retire. Sits between decode/issue and the register file; its writeback inputs are the register file's own write-port signals.

## Interface
- NREGS, 32, architectural register count (index width 5).
- CNTW, 32, width of the performance counters.

- clk  in  1  core clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of all busy state (mispredict/trap).
- iv1_i, iv2_i  in  1 each  decode slot 1/2 holds a valid instruction.
- rs1_1_i, rs2_1_i, rd_1_i  in  5 each  slot 1 source/destination indices.
- rs1_2_i, rs2_2_i, rd_2_i  in  5 each  slot 2 source/destination indices.
- uses_rs1_1_i, uses_rs2_1_i, we_1_i  in  1 each  slot 1 reads rs1/rs2, writes rd.
- uses_rs1_2_i, uses_rs2_2_i, we_2_i  in  1 each  same for slot 2.
- wb_we1_i, wb_we2_i  in  1 each  register-file write enables (port 1, port 2).
- wb_a1_i, wb_a2_i  in  5 each  register-file write addresses.
- issue1_o, issue2_o  out  1 each  slot may issue this cycle (combinational).
- busy_o  out  32  current busy vector (bit 0 always 0).
- err_o  out  1  sticky: writeback to a non-busy register.
- stall_cnt_o  out  CNTW  cycles with iv1_i=1 and issue1_o=0.
- dual_cnt_o  out  CNTW  cycles with both slots issued.

## Operation
- busy[r] set when an issuing slot has we=1 and rd=r≠0; x0 never busy.
- busy[r] cleared when wb_weN_i=1 and wb_aN_i=r≠0.
- Same-cycle set and clear of the same register: set wins (new producer).
- issue1_o = iv1_i & no used source of slot 1 busy & !(we_1_i & busy[rd_1_i]).
- issue2_o = iv2_i & issue1_o (in-order) & same checks on slot 2 against busy & intra-pair checks: slot 2 used rs1/rs2 equals rd_1_i≠0 with we_1_i → block; we_2_i & we_1_i & rd_2_i==rd_1_i≠0 → block.
- Sources/destination equal to x0 never cause a hazard.
- Hazard checks use registered busy only; no same-cycle bypass from writeback (register file write lands at the edge, reads valid next cycle).
- flush_i: all busy bits cleared, counters and err_o unaffected; issue outputs forced 0 that cycle, writebacks that cycle ignored.
- err_o sets when a writeback with a≠0 hits a non-busy bit (not one set the same cycle); cleared only by reset.
- Counters wrap at 2^CNTW; not cleared by flush.

## Timing
- Reset: busy_o=0, err_o=0, stall_cnt_o=0, dual_cnt_o=0; issue outputs follow inputs combinationally (all-clear busy).
- Issue decision: zero-cycle combinational from decode inputs and state.
- Busy set visible on busy_o and hazard logic one cycle after issue; clear visible one cycle after writeback.
- Dependent instruction earliest issue: cycle after producer's writeback cycle.
- Reset assertion mid-operation clears all state immediately, independent of clk.

## Structure
- Shared package: register index width (5), NREGS, x0 index constant, counter width default.
- One natural sub-module: ucsbece154b_sb_hazard — purely combinational per-slot check (sources, rd, busy vector → ok); instantiated twice, slot 2 instance plus intra-pair logic in the top.

## Test plan
- After reset, slot1 add x5 (we=1), slot2 add x6 reading x7 → issue1_o=issue2_o=1; next cycle busy_o=0x0000_0060, dual_cnt_o=1.
- Slot1 writes x5; next cycle slot1 reads x5 → issue1_o=0, issue2_o=0, stall_cnt_o increments each cycle; wb_we1_i=1, wb_a1_i=5 → busy[5]=0 next cycle, issue1_o=1 the cycle after writeback.
- Same pair: slot1 writes x8, slot2 reads x8 → issue1_o=1, issue2_o=0; slot1 and slot2 both write x9 → issue2_o=0.
- Writes/reads to x0 on both slots → always issue, busy_o bit 0 stays 0; wb to x0 does not set err_o.
- Same cycle: wb port 2 clears x10 while slot1 issues write to x10 → busy[10]=1 next cycle, err_o=0; wb to idle x11 → err_o=1 sticky.
- busy_o=0xFFFF_FFFE then flush_i=1 → busy_o=0 next cycle, counters unchanged; reset_n low mid-run → all outputs to reset values without clock edge.
